// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel generator.
//   H_VIS_DEF / V_VIS_DEF : default visible area
//   rgb444_t              : {R[3:0], G[3:0], B[3:0]}
//   BAR_COLORS            : colour-bar palette, left to right
//   motion_state_t        : box motion FSM states
package vga_pkg;

  localparam int H_VIS_DEF = 640;
  localparam int V_VIS_DEF = 480;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t BAR_COLORS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
    12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UPD_X = 2'd1,
    ST_UPD_Y = 2'd2
  } motion_state_t;

endpackage

// File: rtl/vga_box_motion.sv
// Bouncing-box position tracker. Moves the box once per frame, X then Y,
// in the cycles right after frame_tick so the update lands in vertical blanking.
// Ports:
//   clk, reset          : pixel clock, async active-low reset
//   i_frame_tick        : one-cycle pulse per frame
//   i_pause             : 1 holds the box still (sampled at frame_tick)
//   o_box_x, o_box_y    : top-left corner of the box
//
// state    | meaning
// ST_IDLE  | waiting for the next frame tick
// ST_UPD_X | applying the bounce rule to box_x
// ST_UPD_Y | applying the bounce rule to box_y
module vga_box_motion
  import vga_pkg::*;
#(
  parameter int H_VIS    = H_VIS_DEF,
  parameter int V_VIS    = V_VIS_DEF,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_frame_tick,
  input  logic       i_pause,
  output logic [9:0] o_box_x,
  output logic [9:0] o_box_y
);

  localparam logic [10:0] MAXX   = 11'(H_VIS - BOX_SIZE);
  localparam logic [10:0] MAXY   = 11'(V_VIS - BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);

  motion_state_t r_state, w_next;
  logic [9:0]    r_box_x, r_box_y;
  logic          r_dir_x, r_dir_y;    // 1 = moving in the + direction
  logic [10:0]   w_upd_x, w_upd_y;    // {new_dir, new_pos}

  // 11-bit arithmetic so pos+STEP cannot wrap before the limit compare.
  function automatic logic [10:0] bounce(input logic [9:0]  pos,
                                         input logic        dir,
                                         input logic [10:0] maxp);
    logic [10:0] pos_w;
    pos_w = {1'b0, pos};
    if (dir) begin
      if (pos_w + STEP_W >= maxp) return {1'b0, maxp[9:0]};
      return {1'b1, 10'(pos_w + STEP_W)};
    end
    if (pos_w <= STEP_W) return {1'b1, 10'd0};
    return {1'b0, 10'(pos_w - STEP_W)};
  endfunction

  assign w_upd_x = bounce(r_box_x, r_dir_x, MAXX);
  assign w_upd_y = bounce(r_box_y, r_dir_y, MAXY);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_frame_tick && !i_pause) w_next = ST_UPD_X;
      ST_UPD_X: w_next = ST_UPD_Y;
      ST_UPD_Y: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_box_x <= '0;
      r_box_y <= '0;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == ST_UPD_X) {r_dir_x, r_box_x} <= w_upd_x;
      if (r_state == ST_UPD_Y) {r_dir_y, r_box_y} <= w_upd_y;
    end
  end

  assign o_box_x = r_box_x;
  assign o_box_y = r_box_y;

endmodule

// File: rtl/vga_pixel_gen.sv
// Test-pattern pixel generator fed by vga_sync. Two-stage pipeline:
// stage 1 picks the pattern colour from x/y/mode, stage 2 blanks it with vOn
// and re-times the syncs. vOn/hsync/vsync already lag x/y by one cycle, so
// all outputs line up with the x/y presented two cycles earlier.
// Ports:
//   clk, reset            : pixel clock, async active-low reset
//   x, y                  : pixel coordinates
//   vOn, hsync, vsync     : video-on and syncs (one cycle behind x/y)
//   mode                  : 0 black, 1 bars, 2 checker, 3 box over bars
//   pause                 : freezes box motion
//   rgb                   : registered RGB444 pixel
//   hsync_o, vsync_o      : syncs aligned with rgb
//   frame_tick            : one-cycle pulse after (0, V_VIS) is sampled
// Build option: define VGA_BORDER_EN to draw a white 1-pixel frame border.
module vga_pixel_gen
  import vga_pkg::*;
#(
  parameter int      H_VIS     = H_VIS_DEF,
  parameter int      V_VIS     = V_VIS_DEF,
  parameter int      BOX_SIZE  = 32,
  parameter int      STEP      = 2,
  parameter rgb444_t BOX_COLOR = 12'hFF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       vOn,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [1:0] mode,
  input  logic       pause,
  output logic [11:0] rgb,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       frame_tick
);

  localparam int BAR_W = H_VIS / 8;

  rgb444_t     r_color_s1, r_rgb, w_pattern, w_bar_color;
  logic        r_hsync, r_vsync, r_frame_tick;
  logic [9:0]  w_box_x, w_box_y, w_bar_div;
  logic [2:0]  w_bar_idx;
  logic [10:0] w_bx_end, w_by_end;
  logic        w_in_box;

  vga_box_motion #(
    .H_VIS(H_VIS), .V_VIS(V_VIS), .BOX_SIZE(BOX_SIZE), .STEP(STEP)
  ) u_motion (
    .clk         (clk),
    .reset       (reset),
    .i_frame_tick(r_frame_tick),
    .i_pause     (pause),
    .o_box_x     (w_box_x),
    .o_box_y     (w_box_y)
  );

  // Off-screen x gives an index past 7; clamp so the palette read stays legal.
  assign w_bar_div   = 10'(x / 10'(BAR_W));
  assign w_bar_idx   = (w_bar_div > 10'd7) ? 3'd7 : w_bar_div[2:0];
  assign w_bar_color = BAR_COLORS[w_bar_idx];

  assign w_bx_end = {1'b0, w_box_x} + 11'(BOX_SIZE);
  assign w_by_end = {1'b0, w_box_y} + 11'(BOX_SIZE);
  assign w_in_box = (x >= w_box_x) && ({1'b0, x} < w_bx_end) &&
                    (y >= w_box_y) && ({1'b0, y} < w_by_end);

  always_comb begin
    w_pattern = '0;
    case (mode)
      2'd1:    w_pattern = w_bar_color;
      2'd2:    w_pattern = (x[5] ^ y[5]) ? 12'hFFF : 12'h000;
      2'd3:    w_pattern = w_in_box ? BOX_COLOR : w_bar_color;
      default: w_pattern = '0;
    endcase
`ifdef VGA_BORDER_EN
    if (x == 10'd0 || x == 10'(H_VIS - 1) || y == 10'd0 || y == 10'(V_VIS - 1))
      w_pattern = 12'hFFF;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_color_s1   <= '0;
      r_rgb        <= '0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_color_s1   <= w_pattern;
      r_rgb        <= vOn ? r_color_s1 : 12'h000;
      r_hsync      <= hsync;
      r_vsync      <= vsync;
      r_frame_tick <= (x == 10'd0) && (y == 10'(V_VIS));
    end
  end

  assign rgb        = r_rgb;
  assign hsync_o    = r_hsync;
  assign vsync_o    = r_vsync;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_pixel_gen.sv
module tb_vga_pixel_gen;

  localparam int H_VIS = 640;
  localparam int V_VIS = 480;
  localparam int BOX   = 32;
  localparam int STEP  = 2;
  localparam logic [11:0] BOX_COLOR = 12'hFF0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic        vOn = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [1:0]  mode = '0;
  logic        pause = 1'b0;
  logic [11:0] rgb;
  logic        hsync_o, vsync_o, frame_tick;

  always #20 clk = ~clk;

  vga_pixel_gen dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .vOn(vOn), .hsync(hsync),
    .vsync(vsync), .mode(mode), .pause(pause), .rgb(rgb),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0, n_bad = 0;
  int   px = 799, py = 524;           // previous pixel, drives the lagged vOn/syncs
  logic exp_tick = 1'b0;
  logic [1:0] m_mode = 2'd0;
  int   m_bx = 0, m_by = 0;
  logic m_dx = 1'b1, m_dy = 1'b1;
  int   ticks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] bar_of(input int xx);
    if (xx < 80)  return 12'hFFF;
    if (xx < 160) return 12'hFF0;
    if (xx < 240) return 12'h0FF;
    if (xx < 320) return 12'h0F0;
    if (xx < 400) return 12'hF0F;
    if (xx < 480) return 12'hF00;
    if (xx < 560) return 12'h00F;
    return 12'h000;
  endfunction

  function automatic logic [11:0] pat(input int xx, input int yy, input logic [1:0] md);
    logic [11:0] c;
    case (md)
      2'd1:    c = bar_of(xx);
      2'd2:    c = ((((xx / 32) + (yy / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
      2'd3:    c = (xx >= m_bx && xx < m_bx + BOX && yy >= m_by && yy < m_by + BOX)
                   ? BOX_COLOR : bar_of(xx);
      default: c = 12'h000;
    endcase
`ifdef VGA_BORDER_EN
    if (xx == 0 || xx == H_VIS - 1 || yy == 0 || yy == V_VIS - 1) c = 12'hFFF;
`endif
    return c;
  endfunction

  function automatic logic vis(input int xx, input int yy);
    return (xx < H_VIS) && (yy < V_VIS);
  endfunction
  function automatic logic hs_of(input int xx);
    return !(xx >= 656 && xx < 752);
  endfunction
  function automatic logic vs_of(input int yy);
    return !(yy == 490 || yy == 491);
  endfunction

  task automatic model_move();
    if (m_dx) begin
      if (m_bx + STEP >= H_VIS - BOX) begin m_bx = H_VIS - BOX; m_dx = 1'b0; end
      else m_bx = m_bx + STEP;
    end else begin
      if (m_bx <= STEP) begin m_bx = 0; m_dx = 1'b1; end
      else m_bx = m_bx - STEP;
    end
    if (m_dy) begin
      if (m_by + STEP >= V_VIS - BOX) begin m_by = V_VIS - BOX; m_dy = 1'b0; end
      else m_by = m_by + STEP;
    end else begin
      if (m_by <= STEP) begin m_by = 0; m_dy = 1'b1; end
      else m_by = m_by - STEP;
    end
  endtask

  // One pixel per call: check what is due, then drive the next pixel.
  task automatic step(input int xx, input int yy);
    exp_t e;
    @(negedge clk);
    chk("frame_tick", frame_tick, exp_tick);
    if (frame_tick) ticks++;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      chk("rgb", rgb, e.rgb);
      chk("hsync_o", hsync_o, e.hs);
      chk("vsync_o", vsync_o, e.vs);
    end
    mode  = m_mode;
    x     = 10'(xx);
    y     = 10'(yy);
    vOn   = vis(px, py);
    hsync = hs_of(px);
    vsync = vs_of(py);
    e.rgb = vis(xx, yy) ? pat(xx, yy, m_mode) : 12'h000;
    e.hs  = hs_of(xx);
    e.vs  = vs_of(yy);
    sb.push_back(e);
    exp_tick = (xx == 0 && yy == V_VIS);
    if (exp_tick && !pause) model_move();
    px = xx;
    py = yy;
  endtask

  // Compressed frame: probes around the box edges, then the tick and blanking.
  task automatic run_frame(input bit pause_mid);
    ticks = 0;
    step(m_bx, m_by);
    step(m_bx + BOX - 1, m_by + BOX - 1);
    step(m_bx + BOX, m_by);
    step(m_bx, m_by + BOX);
    step((m_bx == 0) ? 0 : m_bx - 1, m_by + 5);
    step(0, V_VIS);
    step(700, 490);
    step(700, 491);
    if (pause_mid) pause = 1'b1;
    step(700, 495);
    step(700, 500);
    step(700, 520);
    chk("ticks_per_frame", ticks, 1);
    chk("box_x", dut.u_motion.o_box_x, m_bx);
    chk("box_y", dut.u_motion.o_box_y, m_by);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bx0, by0, guard;

    // Reset held: outputs at reset values
    x = 10'd0; y = 10'd480; vOn = 1'b1; hsync = 1'b0; vsync = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_hsync_o", hsync_o, 1'b1);
    chk("rst_vsync_o", vsync_o, 1'b1);
    chk("rst_tick", frame_tick, 1'b0);
    chk("rst_box_x", dut.u_motion.o_box_x, 0);
    chk("rst_box_y", dut.u_motion.o_box_y, 0);
    x = 10'd100; y = 10'd100; vOn = 1'b0; hsync = 1'b1; vsync = 1'b1;
    reset = 1'b1;

    // Colour bars over a full line, then blanking with both syncs
    m_mode = 2'd1;
    for (int i = 0; i < 800; i++) step(i, 5);
    for (int j = 486; j < 494; j++) step(660, j);

    // Checkerboard and black
    m_mode = 2'd2;
    step(31, 0); step(32, 0); step(32, 32); step(63, 63); step(64, 64); step(100, 200);
    m_mode = 2'd0;
    step(0, 100); step(300, 300);

    // Box over bars, 10 frames
    m_mode = 2'd3;
    for (int f = 0; f < 10; f++) run_frame(1'b0);
    chk("box_x_10f", dut.u_motion.o_box_x, 20);
    chk("box_y_10f", dut.u_motion.o_box_y, 20);

    // Right-edge bounce
    guard = 0;
    while (!(m_bx == 606 && m_dx) && guard < 400) begin run_frame(1'b0); guard++; end
    run_frame(1'b0);
    chk("bounce_r_x", dut.u_motion.o_box_x, 608);
    chk("bounce_r_dir", dut.u_motion.r_dir_x, 1'b0);
    run_frame(1'b0);
    chk("bounce_r_back", dut.u_motion.o_box_x, 606);

    // Left-edge bounce
    guard = 0;
    while (!(m_bx == 2 && !m_dx) && guard < 400) begin run_frame(1'b0); guard++; end
    run_frame(1'b0);
    chk("bounce_l_x", dut.u_motion.o_box_x, 0);
    chk("bounce_l_dir", dut.u_motion.r_dir_x, 1'b1);

    // Pause holds position, release resumes
    bx0 = m_bx; by0 = m_by;
    pause = 1'b1;
    for (int f = 0; f < 5; f++) run_frame(1'b0);
    chk("pause_x", dut.u_motion.o_box_x, bx0);
    chk("pause_y", dut.u_motion.o_box_y, by0);
    pause = 1'b0;
    run_frame(1'b0);
    // pause raised during the update: this update finishes, the next is skipped
    run_frame(1'b1);
    run_frame(1'b0);
    pause = 1'b0;
    run_frame(1'b0);

    // Async reset mid-line, with hsync_o low and the box away from origin
    m_mode = 2'd1;
    step(10, 50); step(700, 50); step(701, 50); step(702, 50);
    #5 reset = 1'b0;
    #1;
    chk("arst_rgb", rgb, 12'h000);
    chk("arst_hsync_o", hsync_o, 1'b1);
    chk("arst_vsync_o", vsync_o, 1'b1);
    chk("arst_tick", frame_tick, 1'b0);
    chk("arst_box_x", dut.u_motion.o_box_x, 0);
    chk("arst_box_y", dut.u_motion.o_box_y, 0);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    exp_tick = 1'b0;
    m_bx = 0; m_by = 0; m_dx = 1'b1; m_dy = 1'b1;

    m_mode = 2'd0;
    step(0, 100); step(320, 100); step(639, 100); step(5, 479);
    m_mode = 2'd3;
    run_frame(1'b0);
    run_frame(1'b0);
    step(800, 524); step(800, 524);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
